branch_pc_sequencer: RTL and testbench
======================================

Name: branch_pc_sequencer

Overview:
- Owns the program counter and sequences control-flow changes for the RV32I core.
- Consumes the execute-stage compare result, the `branch` output of the branch comparison unit, plus jump decode, and selects the next PC: sequential, branch/JAL target, or JALR target.
- Issues a fetch-flush bubble after every redirect, honours pipeline stalls, and traps on misaligned targets.
- Sits between the execute stage and the instruction fetch stage.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, number of cycles `flush` stays high after a redirect (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  pipeline stall. PC holds and no redirect is accepted.
- valid_ex  input  1  execute stage holds a valid instruction.
- is_branch  input  1  execute instruction is a conditional branch.
- is_jal  input  1  execute instruction is JAL.
- is_jalr  input  1  execute instruction is JALR.
- branch  input  1  comparison result from the branch comparison unit.
- pc_ex  input  XLEN  PC of the execute instruction.
- imm  input  XLEN  sign-extended immediate of the execute instruction.
- rs1  input  XLEN  register-file operand for JALR.
- pc  output  XLEN  current fetch PC (registered).
- pc_valid  output  1  fetch may use `pc` (registered).
- flush  output  1  kill fetch/decode contents (registered).
- trap  output  1  misaligned-target trap, sticky (registered).
- trap_pc  output  XLEN  `pc_ex` of the trapping instruction (registered).

Behaviour:
- Reset, synchronous and active-high, sampled on the clk rising edge:
  - pc=RESET_VECTOR, pc_valid=0, flush=0, trap=0, trap_pc=0.
  - State = RUN, flush counter = 0.
  - pc_valid rises to 1 on the first edge with rst=0.
- Reset mid-redirect or while in TRAP returns the block to RUN immediately and abandons any pending flush.
- Targets, combinational, all arithmetic modulo 2^XLEN, wrap-around without overflow detection:
  - tgt_br = pc_ex + imm (used for branches and JAL).
  - tgt_jr = (rs1 + imm) & ~1 (bit 0 cleared).
- Decode validity: at most one of is_branch/is_jal/is_jalr is high. If more than one is high, priority is is_jalr > is_jal > is_branch.
- take = valid_ex & !stall & state==RUN & (is_jal | is_jalr | (is_branch & branch)).
- Misaligned target: target[1:0] != 0 when take=1.
- States:
  - RUN:
    - take with aligned target: pc <= target, flush <= 1, counter <= FLUSH_CYCLES-1, go to FLUSH.
    - take with misaligned target: trap <= 1, trap_pc <= pc_ex, pc_valid <= 0, flush <= 1, pc holds, go to TRAP.
    - Otherwise, if stall=1: pc holds.
    - Otherwise: pc <= pc + 4.
  - FLUSH:
    - valid_ex is ignored (wrong path).
    - If !stall: pc <= pc + 4.
    - If counter == 0: flush <= 0, go to RUN. Otherwise counter decrements and flush stays 1.
    - Stall does not extend the flush count.
  - TRAP:
    - pc, trap, and trap_pc hold.
    - pc_valid=0. flush deasserts 1 cycle after entry.
    - Exited only by rst.
- Priority per edge: rst > trap entry > redirect > stall > sequential increment.
- A not-taken branch behaves as sequential, with no flush.
- Latency: redirect is visible on `pc` and `flush` one edge after the execute cycle in which take=1.

Test Plan:
- Reset/sequential: assert rst 2 cycles with RESET_VECTOR=0, then release for 3 cycles -> pc=0,4,8,12, pc_valid=1 from the first post-reset edge, flush=0.
- Taken BEQ: pc_ex=0x20, imm=0x40, is_branch=1, branch=1, valid_ex=1 -> next edge pc=0x60, flush=1 for exactly 1 cycle. A valid_ex pulse during FLUSH is ignored. Then pc=0x64.
- Not-taken branch and stall: branch=0 at pc=0x10 -> pc=0x14, no flush. Then stall=1 for 3 cycles together with a taken JAL -> pc holds 0x14 and no redirect. On stall release the JAL is accepted.
- JALR bit-0 clear and wrap: rs1=0xFFFF_FFF0, imm=0x11, is_jalr=1 -> target 0x0000_0000 (0x1 with bit 0 cleared), pc=0x0, flush=1.
- Misaligned trap: JAL with pc_ex=0x100, imm=0x6 -> trap=1, trap_pc=0x100, pc_valid=0, pc unchanged, flush drops after 1 cycle. Further takes are ignored. rst -> trap=0, pc=RESET_VECTOR.
- FLUSH_CYCLES=3 with reset mid-flush: taken branch -> flush high 3 cycles. A repeat run with rst asserted during the 2nd flush cycle -> flush=0 and pc=RESET_VECTOR on the next edge, state RUN.

Source files
------------

// File: rtl/branch_pc_sequencer_if.sv
// Execute-to-fetch control bundle for the PC sequencer.
// The sequencer takes the slave side. A driver such as a testbench or the execute stage takes the master side.
interface branch_pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            valid_ex;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic            branch;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            trap;
  logic [XLEN-1:0] trap_pc;

  modport slave (
    input  stall, valid_ex, is_branch, is_jal, is_jalr, branch, pc_ex, imm, rs1,
    output pc, pc_valid, flush, trap, trap_pc
  );

  modport master (
    output stall, valid_ex, is_branch, is_jal, is_jalr, branch, pc_ex, imm, rs1,
    input  pc, pc_valid, flush, trap, trap_pc
  );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Program counter owner for the RV32I core.
// It selects the next PC, issues a flush bubble after each redirect, and traps on a misaligned target.
module branch_pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              FLUSH_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  branch_pc_sequencer_if.slave bus
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [XLEN-1:0] tgt_br;
  logic [XLEN-1:0] tgt_jr;
  logic [XLEN-1:0] target;
  logic            take;
  logic            misaligned;

  // If several decode bits are high, JALR wins. JAL and branch share the pc_ex-relative target.
  always_comb begin
    tgt_br     = bus.pc_ex + bus.imm;
    tgt_jr     = (bus.rs1 + bus.imm) & ~XLEN'(1);
    target     = bus.is_jalr ? tgt_jr : tgt_br;
    take       = bus.valid_ex & ~bus.stall & (state == RUN) &
                 (bus.is_jal | bus.is_jalr | (bus.is_branch & bus.branch));
    misaligned = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 2'd0;
      bus.pc       <= RESET_VECTOR;
      bus.pc_valid <= 1'b0;
      bus.flush    <= 1'b0;
      bus.trap     <= 1'b0;
      bus.trap_pc  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          bus.pc_valid <= 1'b1;
          if (take && misaligned) begin
            bus.trap     <= 1'b1;
            bus.trap_pc  <= bus.pc_ex;
            bus.pc_valid <= 1'b0;
            bus.flush    <= 1'b1;
            state        <= TRAP;
          end else if (take) begin
            bus.pc    <= target;
            bus.flush <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= FLUSH;
          end else if (!bus.stall) begin
            bus.pc <= bus.pc + XLEN'(4);
          end
        end
        // Wrong-path instructions are ignored here. A stall freezes the PC but not the bubble count.
        FLUSH: begin
          if (!bus.stall) begin
            bus.pc <= bus.pc + XLEN'(4);
          end
          if (cnt == 2'd0) begin
            bus.flush <= 1'b0;
            state     <= RUN;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        TRAP: begin
          bus.pc_valid <= 1'b0;
          bus.flush    <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer. Two instances share the stimulus: one uses FLUSH_CYCLES=1 and one uses FLUSH_CYCLES=3.
module tb_branch_pc_sequencer;

  logic clk;
  logic rst;
  int   compare_count;
  int   fail_count;

  branch_pc_sequencer_if #(.XLEN(32)) bus1 ();
  branch_pc_sequencer_if #(.XLEN(32)) bus3 ();

  branch_pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  branch_pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive identical execute-stage inputs into both instances.
  task automatic applyStimulus(input logic valid, input logic br, input logic jal, input logic jalr,
                               input logic taken, input logic [31:0] pc_ex, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic stall);
    bus1.valid_ex = valid; bus1.is_branch = br; bus1.is_jal = jal; bus1.is_jalr = jalr;
    bus1.branch = taken; bus1.pc_ex = pc_ex; bus1.imm = imm; bus1.rs1 = rs1; bus1.stall = stall;
    bus3.valid_ex = valid; bus3.is_branch = br; bus3.is_jal = jal; bus3.is_jalr = jalr;
    bus3.branch = taken; bus3.pc_ex = pc_ex; bus3.imm = imm; bus3.rs1 = rs1; bus3.stall = stall;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    rst = 1'b1;
    idle();

    // Reset state
    tick(); tick();
    checkOutput("rst_pc", bus1.pc, 32'h0);
    checkOutput("rst_pc_valid", 32'(bus1.pc_valid), 32'h0);
    checkOutput("rst_flush", 32'(bus1.flush), 32'h0);
    checkOutput("rst_trap", 32'(bus1.trap), 32'h0);
    checkOutput("rst_trap_pc", bus1.trap_pc, 32'h0);

    // Sequential fetch after release
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("seq_pc", bus1.pc, 32'(4 * i));
      checkOutput("seq_pc_valid", 32'(bus1.pc_valid), 32'h1);
      checkOutput("seq_flush", 32'(bus1.flush), 32'h0);
    end

    // Taken BEQ, followed by a wrong-path JAL during the flush cycle
    applyStimulus(1, 1, 0, 0, 1, 32'h20, 32'h40, 32'h0, 0);
    tick();
    checkOutput("beq_pc", bus1.pc, 32'h60);
    checkOutput("beq_flush", 32'(bus1.flush), 32'h1);
    applyStimulus(1, 0, 1, 0, 0, 32'h200, 32'h100, 32'h0, 0);
    tick();
    checkOutput("beq_ignore_pc", bus1.pc, 32'h64);
    checkOutput("beq_flush_end", 32'(bus1.flush), 32'h0);

    // JAL to 0x0C so that fetch reaches 0x10
    applyStimulus(1, 0, 1, 0, 0, 32'h0, 32'hC, 32'h0, 0);
    tick();
    checkOutput("jal_pc", bus1.pc, 32'h0C);
    idle();
    tick();
    checkOutput("jal_seq_pc", bus1.pc, 32'h10);

    // Not-taken branch
    applyStimulus(1, 1, 0, 0, 0, 32'h10, 32'h8, 32'h0, 0);
    tick();
    checkOutput("nt_pc", bus1.pc, 32'h14);
    checkOutput("nt_flush", 32'(bus1.flush), 32'h0);

    // Stalled JAL is held for 3 cycles, then accepted
    applyStimulus(1, 0, 1, 0, 0, 32'h14, 32'h20, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_pc", bus1.pc, 32'h14);
      checkOutput("stall_flush", 32'(bus1.flush), 32'h0);
    end
    applyStimulus(1, 0, 1, 0, 0, 32'h14, 32'h20, 32'h0, 0);
    tick();
    checkOutput("unstall_pc", bus1.pc, 32'h34);
    checkOutput("unstall_flush", 32'(bus1.flush), 32'h1);
    idle();
    tick();
    checkOutput("unstall_seq_pc", bus1.pc, 32'h38);

    // JALR target wraps around and has bit 0 cleared
    applyStimulus(1, 0, 0, 1, 0, 32'h38, 32'h11, 32'hFFFF_FFF0, 0);
    tick();
    checkOutput("jalr_pc", bus1.pc, 32'h0);
    checkOutput("jalr_flush", 32'(bus1.flush), 32'h1);
    idle();
    tick();
    checkOutput("jalr_seq_pc", bus1.pc, 32'h4);

    // Misaligned JAL traps, and later takes are ignored
    applyStimulus(1, 0, 1, 0, 0, 32'h100, 32'h6, 32'h0, 0);
    tick();
    checkOutput("trap", 32'(bus1.trap), 32'h1);
    checkOutput("trap_pc", bus1.trap_pc, 32'h100);
    checkOutput("trap_pc_valid", 32'(bus1.pc_valid), 32'h0);
    checkOutput("trap_pc_hold", bus1.pc, 32'h4);
    checkOutput("trap_flush", 32'(bus1.flush), 32'h1);
    applyStimulus(1, 0, 1, 0, 0, 32'h200, 32'h10, 32'h0, 0);
    tick();
    checkOutput("trap_flush_drop", 32'(bus1.flush), 32'h0);
    checkOutput("trap_ignore_pc", bus1.pc, 32'h4);
    tick();
    checkOutput("trap_sticky", 32'(bus1.trap), 32'h1);
    checkOutput("trap_ignore_pc2", bus1.pc, 32'h4);
    rst = 1'b1;
    idle();
    tick();
    checkOutput("trap_rst_trap", 32'(bus1.trap), 32'h0);
    checkOutput("trap_rst_pc", bus1.pc, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_pc", bus3.pc, 32'h4);

    // FLUSH_CYCLES=3: the bubble lasts three cycles
    applyStimulus(1, 1, 0, 0, 1, 32'h20, 32'h40, 32'h0, 0);
    tick();
    checkOutput("f3_pc0", bus3.pc, 32'h60);
    checkOutput("f3_flush0", 32'(bus3.flush), 32'h1);
    idle();
    tick();
    checkOutput("f3_pc1", bus3.pc, 32'h64);
    checkOutput("f3_flush1", 32'(bus3.flush), 32'h1);
    tick();
    checkOutput("f3_pc2", bus3.pc, 32'h68);
    checkOutput("f3_flush2", 32'(bus3.flush), 32'h1);
    tick();
    checkOutput("f3_pc3", bus3.pc, 32'h6C);
    checkOutput("f3_flush3", 32'(bus3.flush), 32'h0);

    // Reset during the second flush cycle abandons the bubble
    applyStimulus(1, 1, 0, 0, 1, 32'h20, 32'h40, 32'h0, 0);
    tick();
    checkOutput("f3r_flush0", 32'(bus3.flush), 32'h1);
    idle();
    tick();
    checkOutput("f3r_flush1", 32'(bus3.flush), 32'h1);
    rst = 1'b1;
    tick();
    checkOutput("f3r_rst_flush", 32'(bus3.flush), 32'h0);
    checkOutput("f3r_rst_pc", bus3.pc, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("f3r_run_pc", bus3.pc, 32'h4);
    checkOutput("f3r_run_flush", 32'(bus3.flush), 32'h0);
    applyStimulus(1, 1, 0, 0, 1, 32'h20, 32'h40, 32'h0, 0);
    tick();
    checkOutput("f3r_take_pc", bus3.pc, 32'h60);
    checkOutput("f3r_take_flush", 32'(bus3.flush), 32'h1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
